// File: rtl/core_dmem_pkg.sv
// Shared definitions for the core data-memory responder: FSM encodings,
// bus widths and the common constants used by the xRV32I memory path.
package core_dmem_pkg;

    localparam int MemByteBus    = 8;
    localparam int MemAddressBus = 32;
    localparam int MemWordBits   = 4 * MemByteBus;

    localparam logic [MemWordBits-1:0] ZeroWord = '0;
    localparam logic WriteEnable  = 1'b1;
    localparam logic DeviceSelect = 1'b1;
    localparam logic HoldNone     = 1'b0;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_READ = 2'd2,
        DMEM_DONE = 2'd3
    } dmem_state_t;

    // Wait counter width: enough to hold the wait count, never narrower than one bit.
    function automatic int cnt_width(input int wait_cycles);
        int w;
        w = $clog2(wait_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/core_dmem_if.sv
// Execute-stage memory request bus; the master is core_ex, the slave is core_dmem.
interface core_dmem_if;
    import core_dmem_pkg::*;

    logic                     mem_req_in;
    logic                     mem_we_in;
    logic [MemAddressBus-1:0] mem_addr_in;
    logic [MemWordBits-1:0]   mem_data_in;
    logic [MemWordBits-1:0]   mem_data_out;
    logic                     mem_ready_out;
    logic                     mem_err_out;
    logic                     hold_flag_out;

    modport master (
        output mem_req_in, mem_we_in, mem_addr_in, mem_data_in,
        input  mem_data_out, mem_ready_out, mem_err_out, hold_flag_out
    );

    modport slave (
        input  mem_req_in, mem_we_in, mem_addr_in, mem_data_in,
        output mem_data_out, mem_ready_out, mem_err_out, hold_flag_out
    );

endinterface

// File: rtl/core_dmem_array.sv
// Word-wide single-port data RAM with a registered read port; contents are
// never reset so they survive a core reset.
module core_dmem_array
    import core_dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic                   re,
    input  logic [AW-1:0]          addr,
    input  logic [MemWordBits-1:0] wdata,
    output logic [MemWordBits-1:0] rdata
);

    logic [MemWordBits-1:0] mem_reg [DEPTH_WORDS];
    logic [MemWordBits-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[addr] <= wdata;
        end
        if (re) begin
            rdata_reg <= mem_reg[addr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/core_dmem.sv
// Data-memory responder: accepts one load/store at a time, inserts WAIT_CYCLES
// wait states, stalls the pipeline until the DONE cycle and commits writes there.
module core_dmem
    import core_dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    core_dmem_if.slave  bus
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = cnt_width(WAIT_CYCLES);
    localparam dmem_state_t AcceptState = (WAIT_CYCLES > 0) ? DMEM_WAIT : DMEM_READ;

    dmem_state_t            state_reg, state_next;
    logic [CW-1:0]          wait_cnt_reg, wait_cnt_next;
    logic [AW-1:0]          idx_reg, idx_next;
    logic                   we_reg, we_next;
    logic                   sel_reg, sel_next;

    logic                   arr_we;
    logic                   arr_re;
    logic [MemWordBits-1:0] arr_rdata;
    logic                   req_in_range;
    logic                   is_done;
    logic                   addr_lsb_unused;

    // Byte offset within the word plays no part in a word access.
    assign addr_lsb_unused = ^bus.mem_addr_in[1:0];
    assign req_in_range    = (bus.mem_addr_in[MemAddressBus-1:2] < (MemAddressBus-2)'(DEPTH_WORDS));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= DMEM_IDLE;
            wait_cnt_reg <= '0;
            idx_reg      <= '0;
            we_reg       <= 1'b0;
            sel_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            idx_reg      <= idx_next;
            we_reg       <= we_next;
            sel_reg      <= sel_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        idx_next      = idx_reg;
        we_next       = we_reg;
        sel_next      = sel_reg;
        arr_we        = 1'b0;
        arr_re        = 1'b0;
        case (state_reg)
            DMEM_IDLE: begin
                if (bus.mem_req_in) begin
                    idx_next      = bus.mem_addr_in[AW+1:2];
                    we_next       = bus.mem_we_in;
                    sel_next      = req_in_range;
                    wait_cnt_next = CW'(WAIT_CYCLES);
                    state_next    = AcceptState;
                end
            end
            DMEM_WAIT: begin
                // A dropped request is a pipeline flush: abandon without side effects.
                if (!bus.mem_req_in) begin
                    wait_cnt_next = '0;
                    state_next    = DMEM_IDLE;
                end else if (wait_cnt_reg <= CW'(1)) begin
                    wait_cnt_next = '0;
                    state_next    = DMEM_READ;
                end else begin
                    wait_cnt_next = wait_cnt_reg - CW'(1);
                end
            end
            DMEM_READ: begin
                if (!bus.mem_req_in) begin
                    state_next = DMEM_IDLE;
                end else begin
                    arr_re     = 1'b1;
                    state_next = DMEM_DONE;
                end
            end
            DMEM_DONE: begin
                arr_we     = (we_reg == WriteEnable) && (sel_reg == DeviceSelect);
                state_next = DMEM_IDLE;
            end
            default: begin
                state_next = DMEM_IDLE;
            end
        endcase
    end

    core_dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .re    (arr_re),
        .addr  (idx_reg),
        .wdata (bus.mem_data_in),
        .rdata (arr_rdata)
    );

    assign is_done           = (state_reg == DMEM_DONE);
    assign bus.mem_ready_out = is_done;
    assign bus.mem_err_out   = is_done && (sel_reg != DeviceSelect);
    assign bus.mem_data_out  = (is_done && (sel_reg == DeviceSelect)) ? arr_rdata : ZeroWord;
    // The stall drops in DONE so the execute stage advances on that edge.
    assign bus.hold_flag_out = (bus.mem_req_in && !is_done) ? ~HoldNone : HoldNone;

endmodule

// File: tb/tb_core_dmem.sv
// Bench for core_dmem: three instances (WAIT_CYCLES 0, 1, 3) driven by directed
// scenarios and random accesses, checked against an associative-array memory model.
module tb_core_dmem;

    localparam int NDUT  = 3;
    localparam int DEPTH = 4096;

    function automatic int wc_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
    endfunction

    logic        clk = 1'b0;
    logic        rst;
    logic        req_r  [NDUT];
    logic        we_r   [NDUT];
    logic [31:0] addr_r [NDUT];
    logic [31:0] wd_r   [NDUT];
    logic [31:0] rd_w   [NDUT];
    logic        rdy_w  [NDUT];
    logic        err_w  [NDUT];
    logic        hold_w [NDUT];

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] mdl [int];
    logic [31:0] last_rd;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        core_dmem_if ifc ();
        assign ifc.mem_req_in  = req_r[gi];
        assign ifc.mem_we_in   = we_r[gi];
        assign ifc.mem_addr_in = addr_r[gi];
        assign ifc.mem_data_in = wd_r[gi];
        assign rd_w[gi]   = ifc.mem_data_out;
        assign rdy_w[gi]  = ifc.mem_ready_out;
        assign err_w[gi]  = ifc.mem_err_out;
        assign hold_w[gi] = ifc.hold_flag_out;

        core_dmem #(
            .DEPTH_WORDS (DEPTH),
            .WAIT_CYCLES (wc_of(gi))
        ) dut (
            .clk (clk),
            .rst (rst),
            .bus (ifc.slave)
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input int k, input string tag);
        check($sformatf("%s_ready%0d", tag, k), {31'b0, rdy_w[k]}, 32'd0);
        check($sformatf("%s_err%0d", tag, k), {31'b0, err_w[k]}, 32'd0);
        check($sformatf("%s_data%0d", tag, k), rd_w[k], 32'd0);
        check($sformatf("%s_hold%0d", tag, k), {31'b0, hold_w[k]}, {31'b0, req_r[k]});
    endtask

    // One complete access; the request is left high on return so a following
    // call forms a back-to-back access.
    task automatic access(input int k, input bit we, input logic [31:0] addr,
                          input logic [31:0] wd, input bit merge, input string tag);
        int          w;
        int          cyc;
        bit          done;
        bit          oor;
        bit          known;
        int          key;
        logic [31:0] exp_rd;
        logic [31:0] obs_rd;
        w     = wc_of(k);
        cyc   = 0;
        done  = 1'b0;
        oor   = (addr[31:2] >= 30'(DEPTH));
        key   = k * DEPTH + int'(addr[13:2]);
        known = oor || mdl.exists(key);
        exp_rd = oor ? 32'd0 : (known ? mdl[key] : 32'd0);

        @(negedge clk);
        req_r[k]  = 1'b1;
        we_r[k]   = we;
        addr_r[k] = addr;
        wd_r[k]   = $urandom;
        while (!done && cyc < 64) begin
            cyc++;
            #1;
            if (rdy_w[k] === 1'b1) begin
                done = 1'b1;
            end else begin
                check($sformatf("%s_hold_c%0d", tag, cyc), {31'b0, hold_w[k]}, 32'd1);
                if (cyc >= 2) begin
                    // Attributes are latched at acceptance; disturb them afterwards.
                    addr_r[k] = $urandom;
                    we_r[k]   = 1'($urandom);
                    wd_r[k]   = $urandom;
                end
                @(negedge clk);
            end
        end
        check($sformatf("%s_cycles", tag), cyc, w + 3);
        obs_rd = rd_w[k];
        last_rd = obs_rd;
        if (done) begin
            check($sformatf("%s_hold_done", tag), {31'b0, hold_w[k]}, 32'd0);
            check($sformatf("%s_err", tag), {31'b0, err_w[k]}, {31'b0, oor});
            if (known) begin
                check($sformatf("%s_data", tag), obs_rd, exp_rd);
            end
            if (we) begin
                wd_r[k] = merge ? {obs_rd[31:16], 8'h99, obs_rd[7:0]} : wd;
                if (!oor) begin
                    mdl[key] = merge ? {exp_rd[31:16], 8'h99, exp_rd[7:0]} : wd;
                end
            end
        end
        $display("dut%0d %s we=%0d addr=%h data=%h err=%0d cycles=%0d",
                 k, tag, we, addr, obs_rd, err_w[k], cyc);
    endtask

    task automatic idle(input int k);
        @(negedge clk);
        req_r[k] = 1'b0;
        #1;
        check_quiet(k, "idle");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int k = 0; k < NDUT; k++) begin
            req_r[k] = 1'b0; we_r[k] = 1'b0; addr_r[k] = '0; wd_r[k] = '0;
        end
        repeat (2) @(negedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) check_quiet(k, "reset");
        rst = 1'b0;

        // Preload words 0..16 on every instance; word 0x10 gets 0xDEADBEEF.
        for (int k = 0; k < NDUT; k++) begin
            for (int i = 0; i < 16; i++) access(k, 1'b1, 32'(i * 4), $urandom, 1'b0, "preload");
            access(k, 1'b1, 32'h40, 32'hDEADBEEF, 1'b0, "preload10");
            idle(k);
        end

        // Read with one wait state.
        access(1, 1'b0, 32'h40, 32'h0, 1'b0, "rd_w1");
        check("rd_w1_const", last_rd, 32'hDEADBEEF);
        idle(1);

        // Store then back-to-back load with no wait states.
        access(0, 1'b1, 32'h44, 32'h12345678, 1'b0, "st_w0");
        access(0, 1'b0, 32'h47, 32'h0, 1'b0, "ld_w0");
        check("ld_w0_const", last_rd, 32'h12345678);

        // Sub-word merge driven from the DONE read data.
        access(0, 1'b1, 32'h44, 32'hAABBCCDD, 1'b0, "mrg_init");
        access(0, 1'b1, 32'h45, 32'h0, 1'b1, "mrg_wr");
        access(0, 1'b0, 32'h44, 32'h0, 1'b0, "mrg_rd");
        check("mrg_const", last_rd, 32'hAABB99DD);
        idle(0);

        // Out of range write then read; word 0 aliases the same low index bits.
        access(1, 1'b1, 32'h4000, 32'hFFFFFFFF, 1'b0, "oor_wr");
        access(1, 1'b0, 32'h4000, 32'h0, 1'b0, "oor_rd");
        check("oor_rd_zero", last_rd, 32'h0);
        access(1, 1'b0, 32'h0, 32'h0, 1'b0, "oor_w0");
        idle(1);

        // Abort a write during WAIT.
        @(negedge clk);
        req_r[2] = 1'b1; we_r[2] = 1'b1; addr_r[2] = 32'h40; wd_r[2] = 32'h0BADF00D;
        #1; check("abort_hold_c1", {31'b0, hold_w[2]}, 32'd1);
        @(negedge clk);
        #1; check("abort_hold_c2", {31'b0, hold_w[2]}, 32'd1);
        check("abort_ready_c2", {31'b0, rdy_w[2]}, 32'd0);
        req_r[2] = 1'b0;
        #1; check("abort_hold_drop", {31'b0, hold_w[2]}, 32'd0);
        access(2, 1'b0, 32'h40, 32'h0, 1'b0, "abort_rd");
        check("abort_rd_const", last_rd, 32'hDEADBEEF);
        idle(2);

        // Reset during WAIT of a write to word 0x10.
        @(negedge clk);
        req_r[1] = 1'b1; we_r[1] = 1'b1; addr_r[1] = 32'h40; wd_r[1] = 32'h0;
        @(negedge clk);
        #1; check("rstw_hold", {31'b0, hold_w[1]}, 32'd1);
        rst = 1'b1;
        req_r[1] = 1'b0;
        @(negedge clk);
        #1; check_quiet(1, "rstw");
        rst = 1'b0;
        access(1, 1'b0, 32'h40, 32'h0, 1'b0, "rstw_rd");
        check("rstw_rd_const", last_rd, 32'hDEADBEEF);
        idle(1);

        // Random traffic on every instance.
        for (int k = 0; k < NDUT; k++) begin
            for (int n = 0; n < 20; n++) begin
                logic [29:0] idx;
                bit          rwe;
                idx = 30'($urandom_range(0, 15));
                if ($urandom_range(0, 7) == 0) idx = idx + 30'(DEPTH * $urandom_range(1, 3));
                rwe = 1'($urandom);
                access(k, rwe, {idx, 2'($urandom)}, $urandom,
                       rwe && ($urandom_range(0, 3) == 0), "rand");
                if ($urandom_range(0, 2) == 0) idle(k);
            end
            idle(k);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
